// File: rtl/dm_stage_pkg.sv
// Shared constants and types for the data-memory stage.
// Holds memory geometry, opcode constants, address-exception codes and the
// decoded memory-operation payload with its opcode decoder.
package dm_stage_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned OP_W      = 6;
    localparam int unsigned EXC_W     = 5;
    localparam int unsigned MEM_WORDS = 3072;
    localparam int unsigned IDX_W     = 12;

    // Highest valid byte address
    localparam logic [DATA_W-1:0] MEM_TOP = 32'h0000_2FFF;

    // Load/store opcodes (instr[31:26])
    localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
    localparam logic [OP_W-1:0] OP_LH  = 6'b100001;
    localparam logic [OP_W-1:0] OP_LHU = 6'b100101;
    localparam logic [OP_W-1:0] OP_LB  = 6'b100000;
    localparam logic [OP_W-1:0] OP_LBU = 6'b100100;
    localparam logic [OP_W-1:0] OP_SW  = 6'b101011;
    localparam logic [OP_W-1:0] OP_SH  = 6'b101001;
    localparam logic [OP_W-1:0] OP_SB  = 6'b101000;

    // Exception codes
    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;

    typedef enum logic [2:0] {
        LD_NONE,
        LD_W,
        LD_H,
        LD_HU,
        LD_B,
        LD_BU
    } ld_type_e;

    typedef enum logic [1:0] {
        ST_NONE,
        ST_W,
        ST_H,
        ST_B
    } st_type_e;

    typedef struct packed {
        ld_type_e ld;
        st_type_e st;
    } mem_op_t;

    // Opcode to load/store kind; anything unlisted is a non-memory op
    function automatic mem_op_t decode_op(input logic [OP_W-1:0] op);
        mem_op_t r;
        r.ld = LD_NONE;
        r.st = ST_NONE;
        case (op)
            OP_LW:   r.ld = LD_W;
            OP_LH:   r.ld = LD_H;
            OP_LHU:  r.ld = LD_HU;
            OP_LB:   r.ld = LD_B;
            OP_LBU:  r.ld = LD_BU;
            OP_SW:   r.st = ST_W;
            OP_SH:   r.st = ST_H;
            OP_SB:   r.st = ST_B;
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_ext.sv
// Load-result extraction and extension.
// Ports:
//   addr_lo  - byte offset within the word (addr[1:0])
//   word     - full memory word read at the load address
//   ld_type  - decoded load kind
//   rdata    - selected, sign-/zero-extended load data (0 for non-loads)
module dm_ext
    import dm_stage_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] word,
    input  ld_type_e          ld_type,
    output logic [DATA_W-1:0] rdata
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    // Half and byte lanes picked by the low address bits
    always_comb begin
        half     = addr_lo[1] ? word[31:16] : word[15:0];
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
    end

    always_comb begin
        rdata = '0;
        case (ld_type)
            LD_W:    rdata = word;
            LD_H:    rdata = {{16{half[15]}}, half};
            LD_HU:   rdata = {16'h0000, half};
            LD_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   rdata = {24'h000000, byte_sel};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dm_stage.sv
// Memory-access stage: 3072-word data memory with byte-granular stores,
// combinational loads and address-exception detection.
// Ports:
//   clk, reset - clock and synchronous active-high reset (clears memory)
//   en         - instruction valid (low for bubble/flush)
//   instr      - instruction word, opcode in instr[31:26]
//   addr       - effective byte address
//   addr_ovf   - address calculation overflowed upstream
//   wdata      - store data (rt)
//   rdata      - extended load result, 0 for non-loads and faulting loads
//   exc        - address exception this cycle
//   exc_code   - 4 for load fault, 5 for store fault, 0 otherwise
module dm_stage
    import dm_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] addr,
    input  logic              addr_ovf,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              exc,
    output logic [EXC_W-1:0]  exc_code
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    mem_op_t           op;
    logic              is_load;
    logic              is_store;
    logic              in_range;
    logic              misaligned;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] wr_word;
    logic [3:0]        be;
    logic              wr_en;
    logic              unused_instr;

    // Only the opcode field matters here
    assign unused_instr = ^instr[25:0];

    assign op       = decode_op(instr[31:26]);
    assign is_load  = (op.ld != LD_NONE);
    assign is_store = (op.st != ST_NONE);
    assign in_range = (addr <= MEM_TOP);

    // Out-of-range addresses never touch the array; their result is discarded
    assign idx     = in_range ? addr[13:2] : '0;
    assign rd_word = mem[idx];

    // Alignment rule depends on access width
    always_comb begin
        misaligned = 1'b0;
        if (op.ld == LD_W || op.st == ST_W) begin
            misaligned = (addr[1:0] != 2'b00);
        end else if (op.ld == LD_H || op.ld == LD_HU || op.st == ST_H) begin
            misaligned = addr[0];
        end
    end

    // All fault causes collapse to one code chosen by load vs store
    always_comb begin
        exc      = 1'b0;
        exc_code = EXC_NONE;
        if (en && (is_load || is_store) && (addr_ovf || misaligned || !in_range)) begin
            exc      = 1'b1;
            exc_code = is_load ? EXC_ADEL : EXC_ADES;
        end
    end

    dm_ext u_ext (
        .addr_lo (addr[1:0]),
        .word    (rd_word),
        .ld_type (op.ld),
        .rdata   (ext_data)
    );

    assign rdata = (en && is_load && !exc) ? ext_data : '0;

    // Byte enables and lane-replicated store data
    always_comb begin
        be      = 4'b0000;
        wr_word = wdata;
        case (op.st)
            ST_W: begin
                be      = 4'b1111;
                wr_word = wdata;
            end
            ST_H: begin
                be      = addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata[15:0]}};
            end
            ST_B: begin
                be      = 4'b0001 << addr[1:0];
                wr_word = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

    assign wr_en = en && is_store && !exc;

    // Reset clears the whole array and takes priority over a coincident store
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_WORDS; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_stage.sv
// Directed self-checking bench for dm_stage.
module tb_dm_stage;
    import dm_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        addr_ovf;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  exc_code;

    int passed;
    int total;

    dm_stage dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .instr    (instr),
        .addr     (addr),
        .addr_ovf (addr_ovf),
        .wdata    (wdata),
        .rdata    (rdata),
        .exc      (exc),
        .exc_code (exc_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one instruction at the falling edge; outputs settle 1ns later,
    // and a store commits on the following rising edge.
    task automatic drive(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic ovf, input logic e);
        @(negedge clk);
        en       = e;
        instr    = {op, 26'h2ABCDE};
        addr     = a;
        addr_ovf = ovf;
        wdata    = wd;
        #1;
    endtask

    task automatic test_reset();
        // Coincident store must be discarded
        @(negedge clk);
        reset    = 1'b1;
        en       = 1'b1;
        instr    = {OP_SW, 26'h0};
        addr     = 32'h40;
        addr_ovf = 1'b0;
        wdata    = 32'hDEADBEEF;
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        drive(OP_LW, 32'h40, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'h0) $display("FAIL reset_store_discard: got %h expected %h", rdata, 32'h0);
        else passed++;
        total++;
        if (exc !== 1'b0 || exc_code !== 5'd0)
            $display("FAIL reset_exc: got exc=%b code=%0d expected exc=0 code=0", exc, exc_code);
        else passed++;
        drive(OP_LW, 32'h10, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'h0) $display("FAIL reset_lw_0x10: got %h expected %h", rdata, 32'h0);
        else passed++;
    endtask

    task automatic test_word();
        drive(OP_SW, 32'h10, 32'h12345678, 1'b0, 1'b1);
        total++;
        if (exc !== 1'b0 || exc_code !== 5'd0)
            $display("FAIL sw_0x10_exc: got exc=%b code=%0d expected exc=0 code=0", exc, exc_code);
        else passed++;
        total++;
        if (rdata !== 32'h0) $display("FAIL sw_rdata_zero: got %h expected %h", rdata, 32'h0);
        else passed++;
        drive(OP_LW, 32'h10, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'h12345678 || exc !== 1'b0)
            $display("FAIL lw_0x10: got %h exc=%b expected 12345678 exc=0", rdata, exc);
        else passed++;
    endtask

    task automatic test_byte();
        drive(OP_SB, 32'h13, 32'hDEADBEAB, 1'b0, 1'b1);
        drive(OP_LB, 32'h13, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'hFFFFFFAB) $display("FAIL lb_0x13: got %h expected FFFFFFAB", rdata);
        else passed++;
        drive(OP_LBU, 32'h13, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'h000000AB) $display("FAIL lbu_0x13: got %h expected 000000AB", rdata);
        else passed++;
        drive(OP_LW, 32'h10, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'hAB345678) $display("FAIL lw_after_sb: got %h expected AB345678", rdata);
        else passed++;
        drive(OP_LBU, 32'h11, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'h00000056) $display("FAIL lbu_0x11: got %h expected 00000056", rdata);
        else passed++;
    endtask

    task automatic test_half();
        drive(OP_SH, 32'h12, 32'h55558001, 1'b0, 1'b1);
        drive(OP_LH, 32'h12, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'hFFFF8001) $display("FAIL lh_0x12: got %h expected FFFF8001", rdata);
        else passed++;
        drive(OP_LHU, 32'h12, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'h00008001) $display("FAIL lhu_0x12: got %h expected 00008001", rdata);
        else passed++;
        drive(OP_LW, 32'h10, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'h80015678) $display("FAIL lw_after_sh: got %h expected 80015678", rdata);
        else passed++;
        drive(OP_LH, 32'h10, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'h00005678) $display("FAIL lh_0x10: got %h expected 00005678", rdata);
        else passed++;
    endtask

    task automatic test_exceptions();
        drive(OP_SW, 32'h11, 32'hCAFEBABE, 1'b0, 1'b1);
        total++;
        if (exc !== 1'b1 || exc_code !== 5'd5)
            $display("FAIL sw_misaligned: got exc=%b code=%0d expected exc=1 code=5", exc, exc_code);
        else passed++;
        drive(OP_LW, 32'h10, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'h80015678) $display("FAIL word_kept_after_fault: got %h expected 80015678", rdata);
        else passed++;
        drive(OP_LH, 32'h3, 32'h0, 1'b0, 1'b1);
        total++;
        if (exc !== 1'b1 || exc_code !== 5'd4 || rdata !== 32'h0)
            $display("FAIL lh_misaligned: got exc=%b code=%0d rdata=%h expected exc=1 code=4 rdata=0", exc, exc_code, rdata);
        else passed++;
        drive(OP_LW, 32'h3000, 32'h0, 1'b0, 1'b1);
        total++;
        if (exc !== 1'b1 || exc_code !== 5'd4 || rdata !== 32'h0)
            $display("FAIL lw_out_of_range: got exc=%b code=%0d rdata=%h expected exc=1 code=4 rdata=0", exc, exc_code, rdata);
        else passed++;
        drive(OP_SW, 32'h20, 32'h77777777, 1'b1, 1'b1);
        total++;
        if (exc !== 1'b1 || exc_code !== 5'd5)
            $display("FAIL sw_ovf: got exc=%b code=%0d expected exc=1 code=5", exc, exc_code);
        else passed++;
        drive(OP_LW, 32'h20, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'h0) $display("FAIL sw_ovf_nowrite: got %h expected 00000000", rdata);
        else passed++;
        // Multiple causes still give a single load code
        drive(OP_LW, 32'h3001, 32'h0, 1'b1, 1'b1);
        total++;
        if (exc_code !== 5'd4) $display("FAIL lw_multi_cause: got code=%0d expected 4", exc_code);
        else passed++;
        drive(OP_SW, 32'h24, 32'h11111111, 1'b0, 1'b0);
        total++;
        if (exc !== 1'b0 || exc_code !== 5'd0)
            $display("FAIL en0_exc: got exc=%b code=%0d expected exc=0 code=0", exc, exc_code);
        else passed++;
        drive(OP_LW, 32'h24, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'h0) $display("FAIL en0_nowrite: got %h expected 00000000", rdata);
        else passed++;
        drive(OP_SW, 32'h11, 32'h0, 1'b0, 1'b0);
        total++;
        if (exc !== 1'b0) $display("FAIL en0_misaligned_exc: got %b expected 0", exc);
        else passed++;
        drive(6'b000000, 32'h3001, 32'h0, 1'b1, 1'b1);
        total++;
        if (exc !== 1'b0 || exc_code !== 5'd0 || rdata !== 32'h0)
            $display("FAIL nonmem: got exc=%b code=%0d rdata=%h expected exc=0 code=0 rdata=0", exc, exc_code, rdata);
        else passed++;
    endtask

    task automatic test_boundary();
        drive(OP_SW, 32'h2FFC, 32'hA5A5A5A5, 1'b0, 1'b1);
        total++;
        if (exc !== 1'b0) $display("FAIL sw_top_exc: got %b expected 0", exc);
        else passed++;
        drive(OP_LW, 32'h2FFC, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'hA5A5A5A5) $display("FAIL lw_top: got %h expected A5A5A5A5", rdata);
        else passed++;
        drive(OP_LB, 32'h2FFF, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'hFFFFFFA5 || exc !== 1'b0)
            $display("FAIL lb_0x2fff: got %h exc=%b expected FFFFFFA5 exc=0", rdata, exc);
        else passed++;
    endtask

    task automatic test_back_to_back();
        drive(OP_SW, 32'h30, 32'h0BADF00D, 1'b0, 1'b1);
        drive(OP_SW, 32'h34, 32'h600DCAFE, 1'b0, 1'b1);
        drive(OP_LW, 32'h34, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'h600DCAFE) $display("FAIL b2b_lw_0x34: got %h expected 600DCAFE", rdata);
        else passed++;
        drive(OP_LW, 32'h30, 32'h0, 1'b0, 1'b1);
        total++;
        if (rdata !== 32'h0BADF00D) $display("FAIL b2b_lw_0x30: got %h expected 0BADF00D", rdata);
        else passed++;
    endtask

    task automatic test_reset_clear();
        logic [31:0] addrs [5];
        addrs[0] = 32'h10;
        addrs[1] = 32'h2FFC;
        addrs[2] = 32'h30;
        addrs[3] = 32'h34;
        addrs[4] = 32'h12;
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(OP_LW, addrs[i], 32'h0, 1'b0, 1'b1);
            total++;
            if (rdata !== 32'h0) $display("FAIL reset_clear_%h: got %h expected 00000000", addrs[i], rdata);
            else passed++;
        end
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        reset    = 1'b1;
        en       = 1'b0;
        instr    = '0;
        addr     = '0;
        addr_ovf = 1'b0;
        wdata    = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_exceptions();
        test_boundary();
        test_back_to_back();
        test_reset_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
